// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type, column-drive constant and key_code layout for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        PRESS_DEB = 2'd1,
        PRESSED   = 2'd2,
        REL_DEB   = 2'd3
    } keypad_state_t;

    localparam logic [3:0] COL_IDLE = 4'b1110;

    localparam int KEY_ROW_MSB = 3;
    localparam int KEY_ROW_LSB = 2;
    localparam int KEY_COL_MSB = 1;
    localparam int KEY_COL_LSB = 0;

    // Rows are active-low; row 0 wins when several are pulled low together.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - width-parameterised two-flop synchronizer with a programmable reset value
module sync_2ff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press and release debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DEB_W   = $clog2(DEBOUNCE_CNT);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

    keypad_state_t      state, state_next;
    logic [1:0]         col_idx, col_idx_next;
    logic [1:0]         row_idx, row_idx_next;
    logic [DWELL_W-1:0] dwell, dwell_next;
    logic [DEB_W-1:0]   deb_cnt, deb_next;
    logic [3:0]         code_next;
    logic               valid_next, held_next;
    logic [3:0]         row_s;
    logic               row_hit;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'b1111)) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (row_in),
        .q     (row_s)
    );

    // The latched row reads low while its key is still down.
    assign row_hit = ~row_s[row_idx];

    always_comb begin
        state_next   = state;
        col_idx_next = col_idx;
        row_idx_next = row_idx;
        dwell_next   = dwell;
        deb_next     = deb_cnt;
        code_next    = key_code;
        valid_next   = 1'b0;
        held_next    = key_held;
        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_next = '0;
                    if (row_s == 4'b1111) begin
                        col_idx_next = col_idx + 2'd1;
                    end else begin
                        row_idx_next = first_low_row(row_s);
                        deb_next     = '0;
                        state_next   = PRESS_DEB;
                    end
                end else begin
                    dwell_next = dwell + 1'b1;
                end
            end
            PRESS_DEB: begin
                if (!row_hit) begin
                    col_idx_next = col_idx + 2'd1;
                    dwell_next   = '0;
                    state_next   = SCAN;
                end else if (deb_cnt == DEB_LAST) begin
                    code_next[KEY_ROW_MSB:KEY_ROW_LSB] = row_idx;
                    code_next[KEY_COL_MSB:KEY_COL_LSB] = col_idx;
                    valid_next = 1'b1;
                    held_next  = 1'b1;
                    state_next = PRESSED;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!row_hit) begin
                    deb_next   = '0;
                    state_next = REL_DEB;
                end
            end
            REL_DEB: begin
                if (row_hit) begin
                    state_next = PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    held_next    = 1'b0;
                    col_idx_next = col_idx + 2'd1;
                    dwell_next   = '0;
                    state_next   = SCAN;
                end else begin
                    deb_next = deb_cnt + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    // col_out is registered from the next column index so the drive never glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            dwell     <= '0;
            deb_cnt   <= '0;
            col_out   <= COL_IDLE;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            col_idx   <= col_idx_next;
            row_idx   <= row_idx_next;
            dwell     <= dwell_next;
            deb_cnt   <= deb_next;
            col_out   <= ~(4'b0001 << col_idx_next);
            key_code  <= code_next;
            key_valid <= valid_next;
            key_held  <= held_next;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a cycle-level keypad reference model
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
    localparam int PH_SCAN = 0, PH_PDEB = 1, PH_HELD = 2, PH_RDEB = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0][3:0] keys = '0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulse_cnt = 0;
    bit   chk_en = 1'b0;

    int         m_phase = PH_SCAN, m_col = 0, m_row = 0, m_dwell = 0, m_stable = 0;
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_rs;
    logic [3:0] m_code = 4'h0;
    logic       m_valid = 1'b0, m_held = 1'b0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clock     (clock),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clock = ~clock;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && col_out[c] == 1'b0) row_in[r] = 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic int lowest_low(input logic [3:0] rs);
        for (int i = 0; i < 4; i++) if (rs[i] == 1'b0) return i;
        return 0;
    endfunction

    // Reference: rows seen two edges late, dwell per column, then a run of DEBOUNCE_CNT agreeing samples.
    always @(posedge clock) begin
        m_rs    = m_s2;
        m_valid = 1'b0;
        if (reset) begin
            m_phase = PH_SCAN; m_col = 0; m_dwell = 0; m_stable = 0;
            m_code = 4'h0; m_held = 1'b0; m_s1 = 4'hF; m_s2 = 4'hF;
        end else begin
            case (m_phase)
                PH_SCAN: begin
                    if (m_dwell == SCAN_DIV - 1) begin
                        m_dwell = 0;
                        if (m_rs == 4'hF) m_col = (m_col + 1) % 4;
                        else begin m_row = lowest_low(m_rs); m_stable = 0; m_phase = PH_PDEB; end
                    end else m_dwell++;
                end
                PH_PDEB: begin
                    if (m_rs[m_row]) begin m_phase = PH_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0; end
                    else begin
                        m_stable++;
                        if (m_stable == DEBOUNCE_CNT) begin
                            m_code = 4'(4 * m_row + m_col); m_valid = 1'b1; m_held = 1'b1; m_phase = PH_HELD;
                        end
                    end
                end
                PH_HELD: if (m_rs[m_row]) begin m_stable = 0; m_phase = PH_RDEB; end
                default: begin
                    if (!m_rs[m_row]) m_phase = PH_HELD;
                    else begin
                        m_stable++;
                        if (m_stable == DEBOUNCE_CNT) begin
                            m_held = 1'b0; m_col = (m_col + 1) % 4; m_dwell = 0; m_phase = PH_SCAN;
                        end
                    end
                end
            endcase
            m_s2 = m_s1;
            m_s1 = row_in;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check_val("col_out", col_out, 4'hF ^ (4'h1 << m_col));
            check_val("key_valid", key_valid, m_valid);
            check_val("key_held", key_held, m_held);
            check_val("key_code", key_code, m_code);
        end
    end

    always @(posedge clock) begin
        #1;
        if (key_valid === 1'b1) pulse_cnt++;
    end

    initial begin
        int p0, r, c, hold;
        logic [3:0] col_seq [5];
        col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        reset = 1'b1;
        cycles(3);
        chk_en = 1'b1;
        check_val("rst_col", col_out, 4'b1110);
        check_val("rst_held", key_held, 1'b0);
        check_val("rst_valid", key_valid, 1'b0);
        check_val("rst_code", key_code, 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_val("scan_col", col_out, col_seq[i]);
            cycles(4);
        end
        check_val("idle_pulses", pulse_cnt, 0);

        p0 = pulse_cnt;
        keys[2][1] = 1'b1;
        cycles(40);
        check_val("s2_pulses", pulse_cnt - p0, 1);
        check_val("s2_code", key_code, 4'b1001);
        check_val("s2_col_frozen", col_out, 4'b1101);
        keys[2][1] = 1'b0;
        cycles(5);
        check_val("s2_held_rel", key_held, 1'b1);
        cycles(10);
        check_val("s2_held_clr", key_held, 1'b0);
        cycles(5);

        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            keys[0][3] = ~keys[0][3];
            cycles(3);
        end
        check_val("s3_bounce_pulses", pulse_cnt - p0, 0);
        keys[0][3] = 1'b1;
        cycles(40);
        check_val("s3_pulses", pulse_cnt - p0, 1);
        check_val("s3_code", key_code, 4'b0011);
        keys[0][3] = 1'b0;
        cycles(20);

        p0 = pulse_cnt;
        keys[1][0] = 1'b1;
        keys[3][0] = 1'b1;
        cycles(40);
        check_val("s4_pulses", pulse_cnt - p0, 1);
        check_val("s4_code", key_code, 4'b0100);
        keys[3][0] = 1'b0;
        cycles(20);
        check_val("s4_held", key_held, 1'b1);
        check_val("s4_pulses_after", pulse_cnt - p0, 1);
        keys[1][0] = 1'b0;
        cycles(20);
        check_val("s4_released", key_held, 1'b0);

        p0 = pulse_cnt;
        keys[3][2] = 1'b1;
        cycles(40);
        check_val("s5_code", key_code, 4'b1110);
        keys[3][2] = 1'b0;
        cycles(5);
        keys[3][2] = 1'b1;
        cycles(2);
        keys[3][2] = 1'b0;
        cycles(6);
        check_val("s5_held_glitch", key_held, 1'b1);
        cycles(10);
        check_val("s5_held_clr", key_held, 1'b0);
        check_val("s5_pulses", pulse_cnt - p0, 1);

        keys[2][3] = 1'b1;
        cycles(40);
        check_val("s6_code_pre", key_code, 4'b1011);
        p0 = pulse_cnt;
        reset = 1'b1;
        cycles(1);
        check_val("s6_rst_col", col_out, 4'b1110);
        check_val("s6_rst_held", key_held, 1'b0);
        check_val("s6_rst_code", key_code, 4'h0);
        reset = 1'b0;
        cycles(2);
        check_val("s6_no_early_pulse", pulse_cnt - p0, 0);
        cycles(38);
        check_val("s6_pulses", pulse_cnt - p0, 1);
        check_val("s6_code", key_code, 4'b1011);
        keys[2][3] = 1'b0;
        cycles(20);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            hold = $urandom_range(0, 50);
            keys[r][c] = 1'b1;
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            for (int k = 0; k < hold; k++) begin
                if ($urandom_range(0, 9) == 0) keys[r][c] = ~keys[r][c];
                reset = ($urandom_range(0, 99) == 0);
                cycles(1);
            end
            reset = 1'b0;
            keys = '0;
            cycles($urandom_range(0, 30));
        end
        cycles(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
